// File: rtl/plantard_pkg.sv
// Shared Plantard constants plus the bp = b * Q^-1 mod 2^(2L) precomputation
// used by whoever feeds plantard_mul_pipe.
package plantard_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_L      = 13;
  localparam int DEF_Q      = 3329;
  localparam int N_STAGES   = 4;

  typedef logic [63:0] wide_t;

  // q*q == 1 mod 8 for odd q, and every Newton step doubles the number of correct bits.
  function automatic wide_t qinv_pow2(input wide_t q, input int unsigned bits);
    wide_t x;
    wide_t mask;
    mask = (wide_t'(1) << bits) - wide_t'(1);
    x    = q;
    for (int i = 0; i < 6; i++) begin
      x = (x * (wide_t'(2) - q * x)) & mask;
    end
    return x;
  endfunction

  function automatic wide_t bp_from_b(input wide_t b, input wide_t q, input int unsigned l);
    wide_t mask;
    mask = (wide_t'(1) << (2 * l)) - wide_t'(1);
    return (b * qinv_pow2(q, 2 * l)) & mask;
  endfunction

endpackage

// File: rtl/plantard_lane.sv
// One lane of the Plantard multiplier: four registered datapath stages sharing
// a single advance enable. Valids and tags live in the parent.
module plantard_lane
  import plantard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int L      = DEF_L,
  parameter int Q      = DEF_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [2*L-1:0]    bp,
  output logic [DATA_W-1:0] c
);

  localparam int PW = DATA_W + L;
  localparam logic [PW-1:0]   Q_M = PW'(Q);
  localparam logic [PW:0]     Q_S = (PW + 1)'(Q);
  localparam logic [DATA_W:0] Q_C = (DATA_W + 1)'(Q);

  logic [PW-1:0] p_lo, p_hi;
  logic [L-1:0]  t;
  logic [PW-1:0] m;

  logic [PW-1:0]     p_lo_d, p_hi_d;
  logic [2*L-1:0]    sum_t;
  logic [PW-1:0]     m_d;
  logic [PW:0]       sum_s;
  logic [DATA_W:0]   s_full;
  logic [DATA_W-1:0] c_d;

  always_comb begin
    p_lo_d = PW'(a) * PW'(bp[L-1:0]);
    p_hi_d = PW'(a) * PW'(bp[2*L-1:L]);
    // Only the low L bits of p_hi survive the mod 2^(2L) after shifting up by L.
    sum_t  = {p_hi[L-1:0], {L{1'b0}}} + (2 * L)'(p_lo);
    m_d    = PW'(t) * Q_M;
    sum_s  = {1'b0, m} + Q_S;
    s_full = sum_s[PW:L];
    c_d    = (s_full == Q_C) ? '0 : s_full[DATA_W-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{p_hi[PW-1:L], sum_t[L-1:0], sum_s[L-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_lo <= '0;
      p_hi <= '0;
      t    <= '0;
      m    <= '0;
      c    <= '0;
    end else if (en) begin
      p_lo <= p_lo_d;
      p_hi <= p_hi_d;
      t    <= sum_t[2*L-1:L];
      m    <= m_d;
      c    <= c_d;
    end
  end

endmodule

// File: rtl/plantard_mul_pipe.sv
// Four-stage Plantard modular multiplier, LANES wide, with a single
// valid/ready handshake, a sideband tag and a synchronous flush.
module plantard_mul_pipe
  import plantard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int L      = DATA_W + 1,
  parameter int Q      = DEF_Q,
  parameter int LANES  = 1,
  parameter int TAG_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_in,
  input  logic [LANES*2*L-1:0]    bp_in,
  input  logic [TAG_W-1:0]        tag_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] c_out,
  output logic [TAG_W-1:0]        tag_out
);

  logic                             en;
  logic                             data_en;
  logic [N_STAGES-1:0]              vld;
  logic [N_STAGES-1:0][TAG_W-1:0]   tag_q;

  assign out_valid = vld[N_STAGES-1];
  assign tag_out   = tag_q[N_STAGES-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  // A flush only kills the valids; data and tag registers keep their contents.
  assign data_en   = en && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[N_STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (data_en) begin
      tag_q <= {tag_q[N_STAGES-2:0], tag_in};
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    plantard_lane #(
      .DATA_W(DATA_W),
      .L     (L),
      .Q     (Q)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .en (data_en),
      .a  (a_in[g*DATA_W +: DATA_W]),
      .bp (bp_in[g*2*L +: 2*L]),
      .c  (c_out[g*DATA_W +: DATA_W])
    );
  end

endmodule
